shift_sched: RTL and testbench
==============================

Name: shift_sched

Overview:
- Two-requester scheduler that shares one 1-bit left-shift stage (shift-by-one, zero fill) between two clients, e.g. branch-offset generation and the ALU.
- Arbitrates between the two clients round-robin.
- Performs a left shift by 0..2^AMT_W-1 positions by applying the 1-bit stage once per clock.
- Returns the result with a per-requester done pulse and an overflow flag.

Parameters:
- WIDTH, 16, data width of operand and result.
- AMT_W, 4, width of shift-amount field; maximum shift is 2^AMT_W-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0  input  1  requester 0 request (level).
- data0  input  WIDTH  requester 0 operand.
- amt0  input  AMT_W  requester 0 shift amount.
- req1  input  1  requester 1 request (level).
- data1  input  WIDTH  requester 1 operand.
- amt1  input  AMT_W  requester 1 shift amount.
- gnt0  output  1  requester 0 owns the shifter (registered).
- gnt1  output  1  requester 1 owns the shifter (registered).
- busy  output  1  transaction in progress (state != IDLE).
- done0  output  1  one-cycle pulse: requester 0 result valid.
- done1  output  1  one-cycle pulse: requester 1 result valid.
- result  output  WIDTH  shifted value, held until the next completion.
- ovf  output  1  a 1 was shifted out of the MSB during the last transaction; held with result.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE; gnt0=gnt1=busy=done0=done1=ovf=0; result=0; accumulator=0; count=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset mid-transaction aborts it with no done pulse; the aborted operand is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - req sampled only in this state.
  - Only one req high: grant it.
  - Both high: grant the requester not equal to last_grant.
  - On the grant edge:
    - accumulator <= data of winner; count <= amt of winner; sticky ovf_acc <= 0.
    - gntX <= 1; last_grant <= winner; -> SHIFT.
  - No req: stay IDLE.
- SHIFT:
  - count==0: -> DONE.
  - Otherwise:
    - accumulator <= {accumulator[WIDTH-2:0],1'b0}.
    - ovf_acc <= ovf_acc | accumulator[WIDTH-1].
    - count <= count-1.
- Entry to DONE (edge leaving SHIFT):
  - result <= accumulator; ovf <= ovf_acc.
  - doneX <= 1 for the granted X.
  - gnt cleared on the same edge.
- DONE: single cycle; doneX pulses high; -> IDLE; done cleared next edge.
- Latency:
  - Request sampled at edge k with amt=N.
  - result/done visible in the cycle after edge k+N+1, i.e. N+2 cycles after the sampling edge.
  - amt=0: 2 cycles, result equals data.
- Throughput: back-to-back requests lose one IDLE cycle between transactions.
- Request handling:
  - Operands are captured at grant; later changes to dataX/amtX or deassertion of reqX have no effect on the transaction.
  - If reqX is still high when IDLE is re-entered, it is treated as a new request.
  - A request arriving while busy waits; it is not queued beyond the level of req.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1,...
- Only one of gnt0/gnt1 may be high; only one of done0/done1 may be high; never both.
- Width rules:
  - Bits shifted past the MSB are lost and set ovf.
  - The LSB is zero-filled.
  - No sign preservation.

Test Plan:
- Reset, then req0=1, data0=0x0005, amt0=1 -> gnt0 next cycle; done0 pulse 3 cycles after the sampling edge; result=0x000A; ovf=0.
- req1 only, data1=0x0013, amt1=4 -> done1 after 6 cycles; result=0x0130; ovf=0. Then amt1=0, data1=0x0007 -> result=0x0007 after 2 cycles.
- req0 and req1 both held from reset, amt=2 each -> grant order 0,1,0,1; exactly one done per transaction; gnt0/gnt1 never both high.
- data0=0x8001, amt0=1 -> result=0x0002, ovf=1. data0=0xFFFF, amt0=15 -> result=0x8000, ovf=1, done after 17 cycles.
- Start req0 with amt0=10; drive rst_n=0 for 1 cycle at the 4th SHIFT cycle -> all outputs 0 next cycle, no done0. A new req1 with amt1=3 completes normally, and requester 0 would win the next tie.
- Change data0/amt0 during SHIFT -> result still reflects the operands captured at the grant edge.

Source files
------------

// File: rtl/shift_sched_if.sv
// Purpose: bundles the two requester channels and the shared shifter's
//          grant/done/result signals between the clients and shift_sched.
// Ports (signals):
//   req0/data0/amt0, req1/data1/amt1 : requests, operands and shift amounts
//   gnt0/gnt1   : registered ownership of the shifter
//   busy        : a transaction is in progress
//   done0/done1 : one-cycle completion pulses
//   result/ovf  : shifted value and its overflow flag, held until the next completion
interface shift_sched_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic [AMT_W-1:0] amt0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic [AMT_W-1:0] amt1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             ovf;

    // Requester side
    modport master (
        output req0, data0, amt0, req1, data1, amt1,
        input  gnt0, gnt1, busy, done0, done1, result, ovf
    );

    // Scheduler side
    modport slave (
        input  req0, data0, amt0, req1, data1, amt1,
        output gnt0, gnt1, busy, done0, done1, result, ovf
    );
endinterface

// File: rtl/shift_sched.sv
// Purpose: round-robin scheduler sharing one 1-bit left-shift stage between
//          two requesters; shifts by amt positions, one position per clock.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : shift_sched_if slave modport (requests in; grants, done pulses,
//           result and overflow out, all registered)
module shift_sched #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    shift_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT            state, stateNxt;
    logic [WIDTH-1:0] acc, accNxt;
    logic [AMT_W-1:0] cnt, cntNxt;
    logic             ovfAcc, ovfAccNxt;
    logic             lastGrant, lastGrantNxt;
    logic             gnt0Q, gnt0Nxt;
    logic             gnt1Q, gnt1Nxt;
    logic             done0Q, done0Nxt;
    logic             done1Q, done1Nxt;
    logic             busyQ, busyNxt;
    logic [WIDTH-1:0] resultQ, resultNxt;
    logic             ovfQ, ovfNxt;
    logic             pick1;

    // Next-state and next-output logic
    always_comb begin
        stateNxt     = state;
        accNxt       = acc;
        cntNxt       = cnt;
        ovfAccNxt    = ovfAcc;
        lastGrantNxt = lastGrant;
        gnt0Nxt      = gnt0Q;
        gnt1Nxt      = gnt1Q;
        done0Nxt     = 1'b0;
        done1Nxt     = 1'b0;
        resultNxt    = resultQ;
        ovfNxt       = ovfQ;
        // Requester 1 wins when alone, or on a tie when 0 was granted last
        pick1        = bus.req1 && (!bus.req0 || !lastGrant);

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    accNxt       = pick1 ? bus.data1 : bus.data0;
                    cntNxt       = pick1 ? bus.amt1 : bus.amt0;
                    ovfAccNxt    = 1'b0;
                    gnt0Nxt      = !pick1;
                    gnt1Nxt      = pick1;
                    lastGrantNxt = pick1;
                    stateNxt     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    resultNxt = acc;
                    ovfNxt    = ovfAcc;
                    done0Nxt  = gnt0Q;
                    done1Nxt  = gnt1Q;
                    gnt0Nxt   = 1'b0;
                    gnt1Nxt   = 1'b0;
                    stateNxt  = DONE;
                end else begin
                    accNxt    = {acc[WIDTH-2:0], 1'b0};
                    ovfAccNxt = ovfAcc | acc[WIDTH-1];
                    cntNxt    = cnt - AMT_W'(1);
                end
            end
            DONE: begin
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        busyNxt = (stateNxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovfAcc    <= 1'b0;
            lastGrant <= 1'b1;
            gnt0Q     <= 1'b0;
            gnt1Q     <= 1'b0;
            done0Q    <= 1'b0;
            done1Q    <= 1'b0;
            busyQ     <= 1'b0;
            resultQ   <= '0;
            ovfQ      <= 1'b0;
        end else begin
            state     <= stateNxt;
            acc       <= accNxt;
            cnt       <= cntNxt;
            ovfAcc    <= ovfAccNxt;
            lastGrant <= lastGrantNxt;
            gnt0Q     <= gnt0Nxt;
            gnt1Q     <= gnt1Nxt;
            done0Q    <= done0Nxt;
            done1Q    <= done1Nxt;
            busyQ     <= busyNxt;
            resultQ   <= resultNxt;
            ovfQ      <= ovfNxt;
        end
    end

    assign bus.gnt0   = gnt0Q;
    assign bus.gnt1   = gnt1Q;
    assign bus.done0  = done0Q;
    assign bus.done1  = done1Q;
    assign bus.busy   = busyQ;
    assign bus.result = resultQ;
    assign bus.ovf    = ovfQ;

endmodule

// File: tb/tb_shift_sched.sv
// Purpose: self-checking bench for shift_sched; directed scenarios plus random
//          request traffic, checked every cycle against a transaction-level model
//          (winner choice, completion edge, result = data << amt truncated).
module tb_shift_sched;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 4;

    logic clk;
    logic rstN;

    shift_sched_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_sched #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edgeNo = 0;

    // Model state: one outstanding transaction described by its winner,
    // captured operands and the edge on which it completes.
    bit               mActive;
    bit               mWin;
    bit               mLast;
    logic [WIDTH-1:0] mData;
    logic [AMT_W-1:0] mAmt;
    int               mDoneEdge;

    logic             eGnt0, eGnt1, eDone0, eDone1, eBusy, eOvf;
    logic [WIDTH-1:0] eResult;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edgeNo, got, exp);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, check outputs.
    task automatic step(input logic rst, input logic r0, input logic [WIDTH-1:0] d0,
                        input logic [AMT_W-1:0] a0, input logic r1,
                        input logic [WIDTH-1:0] d1, input logic [AMT_W-1:0] a1);
        logic [31:0] wide;
        rstN      = rst;
        bus.req0  = r0;
        bus.data0 = d0;
        bus.amt0  = a0;
        bus.req1  = r1;
        bus.data1 = d1;
        bus.amt1  = a1;
        @(posedge clk);
        edgeNo++;
        eDone0 = 1'b0;
        eDone1 = 1'b0;
        if (!rst) begin
            mActive = 1'b0;
            mLast   = 1'b1;
            eGnt0   = 1'b0;
            eGnt1   = 1'b0;
            eBusy   = 1'b0;
            eOvf    = 1'b0;
            eResult = '0;
        end else if (mActive && edgeNo == mDoneEdge) begin
            wide    = 32'(mData) << mAmt;
            eResult = wide[WIDTH-1:0];
            eOvf    = |wide[31:WIDTH];
            eDone0  = !mWin;
            eDone1  = mWin;
            eGnt0   = 1'b0;
            eGnt1   = 1'b0;
            eBusy   = 1'b1;
        end else if (mActive && edgeNo == mDoneEdge + 1) begin
            mActive = 1'b0;
            eBusy   = 1'b0;
        end else if (!mActive && (r0 || r1)) begin
            mWin      = (r0 && r1) ? !mLast : r1;
            mLast     = mWin;
            mData     = mWin ? d1 : d0;
            mAmt      = mWin ? a1 : a0;
            mDoneEdge = edgeNo + int'(mAmt) + 1;
            mActive   = 1'b1;
            eGnt0     = !mWin;
            eGnt1     = mWin;
            eBusy     = 1'b1;
        end
        #1;
        checkVal("gnt0",   32'(bus.gnt0),   32'(eGnt0));
        checkVal("gnt1",   32'(bus.gnt1),   32'(eGnt1));
        checkVal("done0",  32'(bus.done0),  32'(eDone0));
        checkVal("done1",  32'(bus.done1),  32'(eDone1));
        checkVal("busy",   32'(bus.busy),   32'(eBusy));
        checkVal("result", 32'(bus.result), 32'(eResult));
        checkVal("ovf",    32'(bus.ovf),    32'(eOvf));
        checkVal("gntExcl",  32'(bus.gnt0 & bus.gnt1),   32'(0));
        checkVal("doneExcl", 32'(bus.done0 & bus.done1), 32'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Single request pulsed for one cycle, then enough idle cycles to finish.
    task automatic txn(input bit who, input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a);
        if (!who) step(1'b1, 1'b1, d, a, 1'b0, '0, '0);
        else      step(1'b1, 1'b0, '0, '0, 1'b1, d, a);
        idle(int'(a) + 3);
    endtask

    initial begin
        mActive = 1'b0;
        mLast   = 1'b1;
        mWin    = 1'b0;
        mData   = '0;
        mAmt    = '0;
        mDoneEdge = 0;

        // Reset
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 16'hFFFF, 4'd3, 1'b1, 16'hFFFF, 4'd3);
        idle(2);

        // Basic single-requester transactions and boundary amounts
        txn(1'b0, 16'h0005, 4'd1);
        txn(1'b1, 16'h0013, 4'd4);
        txn(1'b1, 16'h0007, 4'd0);
        txn(1'b0, 16'h8001, 4'd1);
        txn(1'b0, 16'hFFFF, 4'd15);

        // Both held from reset: grants alternate starting with 0
        step(1'b0, 1'b1, 16'h0003, 4'd2, 1'b1, 16'h0101, 4'd2);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 16'h0003, 4'd2, 1'b1, 16'h0101, 4'd2);
        idle(5);

        // Reset during the 4th SHIFT cycle of a long transaction
        step(1'b1, 1'b1, 16'h0ABC, 4'd10, 1'b0, '0, '0);
        idle(3);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(3);
        txn(1'b1, 16'h0021, 4'd3);
        step(1'b1, 1'b1, 16'h0040, 4'd1, 1'b1, 16'h0080, 4'd1);
        idle(5);

        // Operand changes during SHIFT are ignored
        step(1'b1, 1'b1, 16'h1234, 4'd5, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'b0, 16'($urandom), 4'($urandom));

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 2) != 0), 16'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0), 16'($urandom), 4'($urandom_range(0, 15)));
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
